// File: rtl/rtc_bus_scheduler_if.sv
// rtc_bus_scheduler_if: request/done and grant signals of the
// shared RTC parallel bus scheduler.
interface rtc_bus_scheduler_if;
  logic       init_req;
  logic       init_done;
  logic       rd_req;
  logic       refresh_en;
  logic       rd_done;
  logic       wr_req;
  logic       wr_done;
  logic       err_clr;
  logic       inicializa;
  logic       lectura;
  logic       escritura;
  logic       busy;
  logic       timeout_err;
  logic [2:0] state_dbg;

  modport master (
    output init_req, init_done, rd_req, refresh_en,
    output rd_done, wr_req, wr_done, err_clr,
    input  inicializa, lectura, escritura,
    input  busy, timeout_err, state_dbg
  );

  modport slave (
    input  init_req, init_done, rd_req, refresh_en,
    input  rd_done, wr_req, wr_done, err_clr,
    output inicializa, lectura, escritura,
    output busy, timeout_err, state_dbg
  );
endinterface

// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler: grants the RTC parallel bus to the init, read or
// write machine, paces refresh sweeps and aborts hung grants.
module rtc_bus_scheduler #(
  parameter int REFRESH_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int GAP_CYCLES     = 4
) (
  input logic                clk,
  input logic                reset,
  rtc_bus_scheduler_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + GAP_CYCLES + 1);
  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    GAP   = 3'd4
  } state_e;

  state_e        state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] ref_cnt;
  logic          rd_pend;
  logic          init_pend;
  logic          last_wr;
  logic          tick;
  logic          wd_exp;
  logic          inicializa;
  logic          lectura;
  logic          escritura;
  logic          busy;
  logic          timeout_err;
  logic [2:0]    state_dbg;

  assign tick   = bus.refresh_en && (ref_cnt == REF_LAST);
  assign wd_exp = (cnt == TO_LAST);

  assign bus.inicializa  = inicializa;
  assign bus.lectura     = lectura;
  assign bus.escritura   = escritura;
  assign bus.busy        = busy;
  assign bus.timeout_err = timeout_err;
  assign bus.state_dbg   = state_dbg;

  // Grants are registered together with the state they belong to.
  task automatic enter(input state_e s);
    state      <= s;
    cnt        <= '0;
    inicializa <= (s == INIT);
    lectura    <= (s == READ);
    escritura  <= (s == WRITE);
    busy       <= (s != IDLE);
    state_dbg  <= s;
  endtask

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= INIT;
      cnt         <= '0;
      ref_cnt     <= '0;
      rd_pend     <= 1'b0;
      init_pend   <= 1'b0;
      last_wr     <= 1'b0;
      inicializa  <= 1'b1;
      lectura     <= 1'b0;
      escritura   <= 1'b0;
      busy        <= 1'b1;
      timeout_err <= 1'b0;
      state_dbg   <= 3'd0;
    end else begin
      if (!bus.refresh_en || tick)
        ref_cnt <= '0;
      else
        ref_cnt <= ref_cnt + RW'(1);

      if (bus.err_clr)
        timeout_err <= 1'b0;

      case (state)
        INIT: begin
          if (bus.init_done) begin
            enter(GAP);
          end else if (wd_exp) begin
            timeout_err <= 1'b1;
            init_pend   <= 1'b1;
            enter(GAP);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        IDLE: begin
          if (init_pend) begin
            init_pend <= 1'b0;
            enter(INIT);
          end else if (bus.wr_req &&
                       (!rd_pend || !last_wr)) begin
            last_wr <= 1'b1;
            enter(WRITE);
          end else if (rd_pend) begin
            last_wr <= 1'b0;
            rd_pend <= 1'b0;
            enter(READ);
          end
        end
        READ, WRITE: begin
          if ((state == READ) ? bus.rd_done
                              : bus.wr_done) begin
            enter(GAP);
          end else if (wd_exp) begin
            timeout_err <= 1'b1;
            enter(GAP);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST)
            enter(IDLE);
          else
            cnt <= cnt + CW'(1);
        end
        default: enter(GAP);
      endcase

      // New requests win over the clear done on grant entry.
      if (tick || bus.rd_req)
        rd_pend <= 1'b1;
      if (bus.init_req)
        init_pend <= 1'b1;
    end
  end
endmodule
